// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store bus interface.
//   lsu_state_e     : access sequencing states
//   F3_*            : RV32I load/store width/sign codes
//   f3_is_legal()   : funct3 legality for a load or a store
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only come in signed-code widths; loads add the two unsigned codes.
  function automatic logic f3_is_legal(input logic we, input logic [2:0] f3);
    logic legal;
    legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) legal = legal || (f3 == F3_BU) || (f3 == F3_HU);
    return legal;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit.
//   we_i        : 1 = store, 0 = load (selects the legal funct3 set)
//   funct3_i    : RV32I width/sign code
//   addr_lo_i   : byte offset within the word
//   wdata_i     : raw store data
//   rdata_i     : raw bus read word
//   be_o        : byte enables
//   wdata_o     : store data replicated across lanes
//   rdata_o     : load data shifted down and sign/zero extended
//   misalign_o  : access crosses its natural alignment
//   illegal_o   : funct3 not valid for this direction
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        illegal_o
);

  logic [31:0] rshift;

  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = '0;
    misalign_o = 1'b0;
    // funct3[1:0] carries the access size for both signed and unsigned codes
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o       = 4'b0011 << addr_lo_i;
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = addr_lo_i[0];
      end
      2'b10: begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        misalign_o = |addr_lo_i;
      end
      default: begin
        be_o       = 4'b0000;
        wdata_o    = '0;
        misalign_o = 1'b0;
      end
    endcase
  end

  assign rshift = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    rdata_o = rshift;
    case (funct3_i)
      F3_B:    rdata_o = {{24{rshift[7]}}, rshift[7:0]};
      F3_H:    rdata_o = {{16{rshift[15]}}, rshift[15:0]};
      F3_W:    rdata_o = rshift;
      F3_BU:   rdata_o = {24'h000000, rshift[7:0]};
      F3_HU:   rdata_o = {16'h0000, rshift[15:0]};
      default: rdata_o = rshift;
    endcase
  end

  assign illegal_o = !f3_is_legal(we_i, funct3_i);

endmodule

// File: rtl/lsu_bus_if.sv
// lsu_bus_if: load/store unit bridging the datapath to a handshaked
// word-addressed memory bus.
//   clk, srst                         : clock, async active-low reset
//   req_valid/we/funct3/addr/wdata    : datapath access request
//   req_ready                         : idle, request will be accepted
//   stall                             : freeze PC / write-back while busy
//   rsp_valid/rsp_rdata/rsp_err       : one-cycle completion, held data/error
//   bus_req/we/addr/be/wdata          : bus request, stable until bus_gnt
//   bus_gnt, bus_rvalid, bus_rdata    : bus grant and read return
//
// state  | meaning
// S_IDLE | ready; accept or reject a request
// S_REQ  | bus_req high, waiting for bus_gnt
// S_WAIT | load granted, waiting for bus_rvalid
// S_RESP | rsp_valid pulse, return to idle
module lsu_bus_if
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              idle;
  logic              in_req;
  logic              al_we;
  logic [2:0]        al_f3;
  logic [1:0]        al_lo;
  logic [3:0]        al_be;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_rdata;
  logic              al_misalign;
  logic              al_illegal;

  assign idle   = (state_q == S_IDLE);
  assign in_req = (state_q == S_REQ);

  // One aligner serves both directions: request fields while idle (store
  // formatting, legality), latched fields afterwards (load extension).
  assign al_we = idle ? req_we         : we_q;
  assign al_f3 = idle ? req_funct3     : f3_q;
  assign al_lo = idle ? req_addr[1:0]  : addr_q[1:0];

  lsu_align u_align (
    .we_i       (al_we),
    .funct3_i   (al_f3),
    .addr_lo_i  (al_lo),
    .wdata_i    (req_wdata),
    .rdata_i    (bus_rdata),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata),
    .misalign_o (al_misalign),
    .illegal_o  (al_illegal)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    addr_d  = addr_q;
    we_d    = we_q;
    f3_d    = f3_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rdata_d = '0;
          if (al_illegal || al_misalign) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            addr_d  = req_addr;
            we_d    = req_we;
            f3_d    = req_funct3;
            be_d    = al_be;
            wdata_d = al_wdata;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        // A store grant on the last budget cycle still completes; a load
        // grant there would need a further WAIT cycle, so it times out.
        if (bus_gnt && we_q) begin
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else if (bus_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_rvalid) begin
          rdata_d = al_rdata;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = idle;
  assign stall     = (idle && req_valid) || in_req || (state_q == S_WAIT);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Bus outputs are gated to REQ so they read zero while idle and in reset.
  assign bus_req   = in_req;
  assign bus_we    = in_req && we_q;
  assign bus_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus_be    = in_req ? be_q : 4'b0000;
  assign bus_wdata = in_req ? wdata_q : '0;

endmodule
